// File: rtl/pc_sequencer_if.sv
// Request/response channels between the pc sequencer and its fetch, execute and branch units.
// Each channel is a level request (X_en) answered by a done strobe plus its data.
interface pc_sequencer_if;
  logic        fetch_en;
  logic        fetch_done;
  logic [31:0] fetch_instr;
  logic        exec_en;
  logic        exec_done;
  logic        is_branch;
  logic        branch_en;
  logic        branch_done;
  logic [31:0] branch_pc;

  modport master (
    output fetch_en, exec_en, branch_en,
    input  fetch_done, fetch_instr, exec_done, is_branch, branch_done, branch_pc
  );

  modport slave (
    input  fetch_en, exec_en, branch_en,
    output fetch_done, fetch_instr, exec_done, is_branch, branch_done, branch_pc
  );
endinterface

// File: rtl/pc_sequencer.sv
// Instruction sequencer: drives fetch -> exec -> (branch) -> pc update with per-request timeouts.
// All outputs are registered; HALTED and ERROR are sticky until rst_n.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           halt_req,
  pc_sequencer_if.master bus,
  output logic [31:0]    pc,
  output logic [31:0]    instr,
  output logic           busy,
  output logic           halted,
  output logic           error
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_BRANCH, S_UPDATE, S_HALTED, S_ERROR
  } state_t;

  state_t        state, state_d;
  logic          fetch_en_q, exec_en_q, branch_en_q;
  logic          fetch_en_d, exec_en_d, branch_en_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [31:0]   next_pc, next_pc_d;
  logic [31:0]   pc_d, instr_d;
  logic          halt_pend, halt_pend_d;

  assign bus.fetch_en  = fetch_en_q;
  assign bus.exec_en   = exec_en_q;
  assign bus.branch_en = branch_en_q;

  // A request level rises only once done has been seen low since entering the
  // state, so a stale done left over from a previous transfer is never taken
  // as completion. Entering a request state samples done on that same edge.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d     = state;
    fetch_en_d  = 1'b0;
    exec_en_d   = 1'b0;
    branch_en_d = 1'b0;
    cnt_d       = cnt;
    next_pc_d   = next_pc;
    pc_d        = pc;
    instr_d     = instr;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_d    = S_FETCH;
          fetch_en_d = !bus.fetch_done;
          cnt_d      = '0;
        end
      end

      S_FETCH: begin
        if (fetch_en_q && bus.fetch_done) begin
          instr_d = bus.fetch_instr;
          cnt_d   = '0;
          if (bus.fetch_instr == HALT_WORD) begin
            state_d = S_HALTED;
          end else begin
            state_d   = S_EXEC;
            exec_en_d = !bus.exec_done;
          end
        end else if (cnt == CNT_LAST) begin
          state_d = S_ERROR;
        end else begin
          fetch_en_d = fetch_en_q || !bus.fetch_done;
          cnt_d      = cnt + CW'(1);
        end
      end

      S_EXEC: begin
        if (exec_en_q && bus.exec_done) begin
          cnt_d = '0;
          if (bus.is_branch) begin
            state_d     = S_BRANCH;
            branch_en_d = !bus.branch_done;
          end else begin
            state_d   = S_UPDATE;
            next_pc_d = pc + 32'd4;
          end
        end else if (cnt == CNT_LAST) begin
          state_d = S_ERROR;
        end else begin
          exec_en_d = exec_en_q || !bus.exec_done;
          cnt_d     = cnt + CW'(1);
        end
      end

      S_BRANCH: begin
        if (branch_en_q && bus.branch_done) begin
          cnt_d     = '0;
          state_d   = S_UPDATE;
          next_pc_d = bus.branch_pc;
        end else if (cnt == CNT_LAST) begin
          state_d = S_ERROR;
        end else begin
          branch_en_d = branch_en_q || !bus.branch_done;
          cnt_d       = cnt + CW'(1);
        end
      end

      S_UPDATE: begin
        pc_d  = next_pc;
        cnt_d = '0;
        if (halt_pend || halt_req) begin
          state_d = S_IDLE;
        end else begin
          state_d    = S_FETCH;
          fetch_en_d = !bus.fetch_done;
        end
      end

      S_HALTED, S_ERROR: ;

      default: state_d = S_ERROR;
    endcase

    // A halt seen while running is held until the sequencer parks in IDLE.
    halt_pend_d = (state_d == S_IDLE) ? 1'b0 : (halt_pend || (busy && halt_req));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      fetch_en_q  <= 1'b0;
      exec_en_q   <= 1'b0;
      branch_en_q <= 1'b0;
      cnt         <= '0;
      next_pc     <= RESET_PC;
      pc          <= RESET_PC;
      instr       <= '0;
      halt_pend   <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      error       <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop sees pre-edge values.
      state       <= state_d;
      fetch_en_q  <= fetch_en_d;
      exec_en_q   <= exec_en_d;
      branch_en_q <= branch_en_d;
      cnt         <= cnt_d;
      next_pc     <= next_pc_d;
      pc          <= pc_d;
      instr       <= instr_d;
      halt_pend   <= halt_pend_d;
      busy        <= state_d inside {S_FETCH, S_EXEC, S_BRANCH, S_UPDATE};
      halted      <= (state_d == S_HALTED);
      error       <= (state_d == S_ERROR);
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: registered responders play a program table,
// a scoreboard holds expected pc updates and FETCH-to-FETCH latencies.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned TIMEOUT  = 8;

  typedef struct {
    bit [31:0] instr;
    bit        is_br;
    bit [31:0] bpc;
  } prog_t;

  typedef struct {
    logic [31:0] pc;
    int unsigned lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        halt_req;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        busy;
  logic        halted;
  logic        error;

  pc_sequencer_if bus ();

  pc_sequencer #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .halt_req (halt_req),
    .bus      (bus.master),
    .pc       (pc),
    .instr    (instr),
    .busy     (busy),
    .halted   (halted),
    .error    (error)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_err = 0;
  prog_t prog [64];
  int    n_prog;
  logic [31:0] mpc;
  exp_t  sb [$];
  bit    exec_stall;
  bit    branch_force;
  int    fi;
  int    cur;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Registered responders: done follows the request by one cycle and pulses once.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.fetch_done  <= 1'b0;
      bus.exec_done   <= 1'b0;
      bus.branch_done <= 1'b0;
      bus.fetch_instr <= '0;
      fi  <= 0;
      cur <= 0;
    end else begin
      bus.fetch_done <= bus.fetch_en && !bus.fetch_done;
      if (bus.fetch_en && !bus.fetch_done) begin
        bus.fetch_instr <= prog[fi].instr;
        cur <= fi;
        fi  <= fi + 1;
      end
      bus.exec_done   <= !exec_stall && bus.exec_en && !bus.exec_done;
      bus.branch_done <= branch_force || (bus.branch_en && !bus.branch_done);
    end
  end

  assign bus.is_branch = prog[cur].is_br;
  assign bus.branch_pc = prog[cur].bpc;

  // Monitor: pops the scoreboard on every committed pc change.
  int   cyc = 0;
  int   fetch_cyc = 0;
  int   exec_cyc = 0;
  int   err_cyc = 0;
  int   onehot_viol = 0;
  logic prev_fe, prev_ee, prev_err;
  logic [31:0] prev_pc;

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if ($countones({bus.fetch_en, bus.exec_en, bus.branch_en}) > 1) onehot_viol++;
    if (rst_n === 1'b1 && pc !== prev_pc) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_pc", pc, prev_pc);
      end else begin
        e = sb.pop_front();
        check("sb_pc", pc, e.pc);
        check("sb_latency", 32'(cyc - fetch_cyc), e.lat);
      end
    end
    prev_pc = pc;
    if (bus.fetch_en === 1'b1 && prev_fe !== 1'b1) fetch_cyc = cyc;
    if (bus.exec_en === 1'b1 && prev_ee !== 1'b1) exec_cyc = cyc;
    if (error === 1'b1 && prev_err !== 1'b1) err_cyc = cyc;
    prev_fe  = bus.fetch_en;
    prev_ee  = bus.exec_en;
    prev_err = error;
  end

  // lat = 0 marks an instruction whose pc update is not expected to commit.
  task automatic add(input bit [31:0] ins, input bit br, input bit [31:0] bpc, input int unsigned lat);
    exp_t e;
    prog[n_prog] = '{ins, br, bpc};
    n_prog++;
    if (ins != 32'hFFFF_FFFF) begin
      mpc = br ? bpc : mpc + 32'd4;
      if (lat != 0) begin
        e.pc  = mpc;
        e.lat = lat;
        sb.push_back(e);
      end
    end
  endtask

  task automatic do_reset();
    check("sb_drain", 32'(sb.size()), 0);
    rst_n = 1'b0;
    #1;
    check("rst_pc", pc, RESET_PC);
    check("rst_en", {bus.fetch_en, bus.exec_en, bus.branch_en}, 0);
    check("rst_status", {busy, halted, error}, 0);
    check("rst_instr", instr, 0);
    sb.delete();
    n_prog       = 0;
    mpc          = RESET_PC;
    exec_stall   = 1'b0;
    branch_force = 1'b0;
    start        = 1'b0;
    halt_req     = 1'b0;
    for (int i = 0; i < 64; i++) prog[i] = '{32'h0, 1'b0, 32'h0};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start(input bit with_halt);
    start    = 1'b1;
    halt_req = with_halt;
    @(negedge clk);
    start    = 1'b0;
    halt_req = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300 && busy !== 1'b0; i++) @(negedge clk);
    check(tag, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    halt_req = 1'b0;
    exec_stall = 1'b0;
    branch_force = 1'b0;
    @(negedge clk);

    // Straight-line code, taken branches, pc wrap, then a halt word.
    do_reset();
    add(32'h2002_0005, 0, 0, 5);
    add(32'h2002_0006, 0, 0, 5);
    add(32'h2002_0007, 0, 0, 5);
    add(32'h2002_0008, 0, 0, 5);
    add(32'h1000_0001, 1, 32'h0000_0040, 7);
    add(32'h1000_0002, 1, 32'hFFFF_FFFC, 7);
    add(32'h2002_0009, 0, 0, 5);
    add(32'hFFFF_FFFF, 0, 0, 0);
    pulse_start(1'b0);
    wait_idle("a_idle");
    check("a_halted", halted, 1);
    check("a_pc_wrap", pc, 32'h0);
    check("a_instr", instr, 32'hFFFF_FFFF);
    pulse_start(1'b0);
    repeat (6) @(negedge clk);
    check("a_start_ignored", {busy, halted, error, bus.fetch_en}, 4'b0100);

    // Not-taken branch, halt_req during EXEC, resume with start+halt together.
    do_reset();
    add(32'h2002_0005, 0, 0, 5);
    add(32'h2002_0006, 0, 0, 5);
    add(32'h2002_0007, 0, 0, 5);
    add(32'h2002_0008, 0, 0, 5);
    add(32'h1000_0003, 1, 32'h0000_0014, 7);
    add(32'h2002_000A, 0, 0, 5);
    add(32'h2002_000B, 0, 0, 5);
    add(32'hFFFF_FFFF, 0, 0, 0);
    pulse_start(1'b0);
    for (int i = 0; i < 200 && !(pc === 32'h14 && bus.exec_en === 1'b1); i++) @(negedge clk);
    check("b_halt_point", {pc, bus.exec_en}, {32'h14, 1'b1});
    halt_req = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    wait_idle("b_idle");
    repeat (5) @(negedge clk);
    check("b_paused", {busy, halted, error}, 0);
    check("b_pc_paused", pc, 32'h18);
    pulse_start(1'b1);
    wait_idle("b_idle2");
    check("b_halted", halted, 1);
    check("b_pc_final", pc, 32'h1C);

    // Execute responder never answers: timeout into ERROR.
    do_reset();
    exec_stall = 1'b1;
    add(32'h2002_0005, 0, 0, 0);
    pulse_start(1'b0);
    wait_idle("c_idle");
    check("c_error", {error, halted, bus.exec_en}, 3'b100);
    check("c_timeout_cycles", 32'(err_cyc - exec_cyc), TIMEOUT);
    pulse_start(1'b0);
    repeat (4) @(negedge clk);
    check("c_sticky", {busy, error}, 2'b01);

    // Stale branch_done on BRANCH entry, then reset while branch_en is high.
    do_reset();
    branch_force = 1'b1;
    add(32'h1000_0004, 1, 32'h0000_0100, 11);
    add(32'h1000_0005, 1, 32'h0000_0200, 0);
    pulse_start(1'b0);
    for (int i = 0; i < 50 && bus.exec_en !== 1'b1; i++) @(negedge clk);
    for (int i = 0; i < 50 && bus.exec_en !== 1'b0; i++) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      check("d_stale_hold", {busy, bus.branch_done, bus.branch_en}, 3'b110);
    end
    branch_force = 1'b0;
    for (int i = 0; i < 100 && pc !== 32'h100; i++) @(negedge clk);
    check("d_pc_branch", pc, 32'h100);
    for (int i = 0; i < 100 && bus.branch_en !== 1'b1; i++) @(negedge clk);
    check("d_branch_en", bus.branch_en, 1);
    do_reset();

    check("onehot_en", onehot_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter TIMEOUT, default 64, maximum cycles a request may wait for its done before error.
REQ-003 SHALL have one clock; reset is asynchronous and active-low: clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  begin execution from current pc; honoured only in IDLE.
REQ-006 halt_req  input  1  finish current instruction, then return to IDLE.
REQ-007 fetch_en  output  1  fetch request level; fetch_done  input  1  fetch complete; fetch_instr  input  32  fetched word.
REQ-008 exec_en  output  1  execute request level; exec_done  input  1  execute complete; is_branch  input  1  instruction is a branch, valid with exec_done.
REQ-009 branch_en  output  1  branch-unit request level; branch_done  input  1  branch complete; branch_pc  input  32  resolved next pc, valid with branch_done.
REQ-010 pc  output  32  current pc; instr  output  32  latched instruction; busy  output  1  not in IDLE/HALTED/ERROR; halted  output  1; error  output  1.

Function
REQ-011 SHALL implement states IDLE, FETCH, EXEC, BRANCH, UPDATE, HALTED, ERROR; all outputs registered/Moore.
REQ-012 IDLE: start=1 -> FETCH; otherwise stay.
REQ-013 Request rule (FETCH/EXEC/BRANCH): X_en SHALL be 1 in the state only while X_done sampled 0 has been seen since state entry; if X_done is 1 on entry (stale), X_en stays 0 until X_done samples 0.
REQ-014 Transition out of a request state SHALL occur on the edge where X_en=1 and X_done=1 are sampled; X_en SHALL be 0 from the following cycle.
REQ-015 FETCH complete: instr <= fetch_instr; if fetch_instr == 32'hFFFF_FFFF -> HALTED (pc unchanged), else -> EXEC.
REQ-016 EXEC complete: is_branch=1 -> BRANCH, else -> UPDATE with next pc = pc + 4.
REQ-017 BRANCH complete: next pc = branch_pc (taken or not-taken value supplied by branch unit) -> UPDATE.
REQ-018 UPDATE (one cycle): pc <= next pc; then IDLE if halt pending, else FETCH.
REQ-019 pc arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
REQ-020 halt_req SHALL be latched when busy=1 and cleared on entering IDLE; halt_req in IDLE is ignored; start and halt_req in same IDLE cycle -> start wins.
REQ-021 start while busy, HALTED or ERROR SHALL be ignored.
REQ-022 Per-request counter SHALL reset on each request-state entry and count cycles in state; reaching TIMEOUT without completion -> ERROR, all en 0, error=1.
REQ-023 HALTED and ERROR SHALL be sticky until reset; halted=1 only in HALTED.
REQ-024 Minimum latency: state entry to completion 2 cycles per request (responder done registered); non-branch instruction 5 cycles FETCH-entry to next FETCH-entry, branch instruction 7.
REQ-025 At most one of fetch_en, exec_en, branch_en SHALL be 1 in any cycle.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, pc=RESET_PC, instr=0, all en=0, busy=0, halted=0, error=0, halt latch=0, counter=0, regardless of state.
REQ-027 Reset asserted mid-request SHALL drop the active en in the same cycle without waiting for done.

Verification
REQ-028 Reset, start pulse, responders with 1-cycle done, is_branch=0, instr 32'h2002_0005 -> pc 0 -> 4 after 5 cycles, then 8; exactly one en high at a time.
REQ-029 pc=32'h10, is_branch=1, branch_pc=32'h40 -> pc=32'h40 at UPDATE, 7 cycles per instruction; branch_pc=32'h14 (not taken) -> pc=32'h14.
REQ-030 fetch_instr=32'hFFFF_FFFF -> HALTED, halted=1, pc unchanged; start ignored; only rst_n clears.
REQ-031 halt_req pulse during EXEC -> instruction completes, pc updated, IDLE, busy=0; later start resumes from updated pc.
REQ-032 exec_done held 0 with TIMEOUT=8 -> ERROR after 8 cycles in EXEC, error=1, exec_en=0; stale branch_done=1 on BRANCH entry -> branch_en held 0 until it falls.
REQ-033 rst_n low during BRANCH with branch_en=1 -> branch_en=0 same cycle, pc=RESET_PC; pc=32'hFFFF_FFFC non-branch -> pc=0.
